// File: rtl/bidir_bus_buffer.sv
// bidir_bus_buffer: DEPTH-entry FIFO sitting on a shared bidirectional bus.
// In RX it captures bus words and holds the last one on data_out. In TX it
// drives stored words back onto the bus, one pop per drv_en. Every direction
// change leaves the bus released for TURNAROUND idle cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   data_io    shared bus, driven only while in TX, otherwise high-Z
//   dir_tx     requested direction (1 = transmit, 0 = receive)
//   cap_en     capture strobe, pushes data_io while in RX
//   drv_en     advance strobe, pops the FIFO head while in TX
//   clr_err    synchronous clear of overflow/underflow
//   data_out   last captured bus word
//   count      FIFO occupancy 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   tx_active  high exactly while data_io is driven
//   overflow   sticky: capture attempted while full
//   underflow  sticky: advance attempted while empty
module bidir_bus_buffer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    inout  wire  [WIDTH-1:0]         data_io,
    input  logic                     dir_tx,
    input  logic                     cap_en,
    input  logic                     drv_en,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     tx_active,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = 4;
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURNAROUND);

    typedef enum logic [1:0] {
        ST_RX      = 2'd0,
        ST_TURN_TX = 2'd1,
        ST_TX      = 2'd2,
        ST_TURN_RX = 2'd3
    } state_t;

    state_t          state;
    logic [TW-1:0]   turn_cnt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic            push;

    // Occupancy flags come straight from the registered count.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = (state == ST_RX) && cap_en && !full;

    // tx_active mirrors state TX, so the reset clears the bus driver at once.
    assign data_io = tx_active ? mem[rd_ptr] : {WIDTH{1'bz}};

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_io;
        end
    end

    // Direction FSM, pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RX;
            turn_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            tx_active <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Clear first so that an error raised in the same cycle wins.
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            case (state)
                ST_RX: begin
                    if (cap_en) begin
                        data_out <= data_io;
                        if (full) begin
                            overflow <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + AW'(1);
                            count  <= count + CW'(1);
                        end
                    end
                    if (dir_tx) begin
                        if (TURNAROUND == 0) begin
                            state     <= ST_TX;
                            tx_active <= 1'b1;
                        end else begin
                            state    <= ST_TURN_TX;
                            turn_cnt <= TURN_LOAD;
                        end
                    end
                end
                ST_TURN_TX: begin
                    // Leave after exactly TURNAROUND cycles, ignoring dir_tx.
                    if (turn_cnt <= TW'(1)) begin
                        state     <= ST_TX;
                        tx_active <= 1'b1;
                    end else begin
                        turn_cnt <= turn_cnt - TW'(1);
                    end
                end
                ST_TX: begin
                    if (drv_en) begin
                        if (empty) begin
                            underflow <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + AW'(1);
                            count  <= count - CW'(1);
                        end
                    end
                    if (!dir_tx) begin
                        tx_active <= 1'b0;
                        if (TURNAROUND == 0) begin
                            state <= ST_RX;
                        end else begin
                            state    <= ST_TURN_RX;
                            turn_cnt <= TURN_LOAD;
                        end
                    end
                end
                ST_TURN_RX: begin
                    if (turn_cnt <= TW'(1)) begin
                        state <= ST_RX;
                    end else begin
                        turn_cnt <= turn_cnt - TW'(1);
                    end
                end
                default: begin
                    state     <= ST_RX;
                    tx_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bidir_bus_buffer.sv
// Testbench for bidir_bus_buffer: directed vector table, an asynchronous
// reset sequence in the middle of TX, then random traffic against a
// queue-based reference model.
module tb_bidir_bus_buffer;

    localparam int unsigned W     = 16;
    localparam int unsigned D     = 4;
    localparam int unsigned T     = 1;
    localparam int unsigned CW    = $clog2(D) + 1;
    localparam int          NRAND = 3000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dir_tx = 1'b0, cap_en = 1'b0, drv_en = 1'b0, clr_err = 1'b0;
    logic [W-1:0]  bus_drv = '0;
    logic          bus_en = 1'b0;
    wire  [W-1:0]  data_io;
    logic [W-1:0]  data_out;
    logic [CW-1:0] count;
    logic          full, empty, tx_active, overflow, underflow;

    assign data_io = bus_en ? bus_drv : {W{1'bz}};

    bidir_bus_buffer #(.WIDTH(W), .DEPTH(D), .TURNAROUND(T)) dut (
        .clk(clk), .rst(rst), .data_io(data_io), .dir_tx(dir_tx),
        .cap_en(cap_en), .drv_en(drv_en), .clr_err(clr_err),
        .data_out(data_out), .count(count), .full(full), .empty(empty),
        .tx_active(tx_active), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock cycle of inputs plus the outputs expected after its edge.
    typedef struct {
        logic         dir, cap, drv, clr, drive;
        logic [W-1:0] bus;
        int           cnt;
        logic [W-1:0] dout;
        logic         tx, ov, uf, chkbus;
        logic [W-1:0] exp_bus;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic dir, cap, drv, clr, drive,
                                input logic [W-1:0] bus, input int cnt,
                                input logic [W-1:0] dout, input logic tx, ov, uf,
                                input logic chkbus, input logic [W-1:0] exp_bus);
        vec_t v;
        v.dir = dir; v.cap = cap; v.drv = drv; v.clr = clr; v.drive = drive;
        v.bus = bus; v.cnt = cnt; v.dout = dout; v.tx = tx; v.ov = ov; v.uf = uf;
        v.chkbus = chkbus; v.exp_bus = exp_bus;
        return v;
    endfunction

    task automatic check_outputs(input string tag, input int cnt, input logic [W-1:0] dout,
                                 input logic tx, ov, uf, chkbus, input logic [W-1:0] exp_bus);
        chk({tag, "_count"}, 32'(count), 32'(cnt));
        chk({tag, "_full"}, 32'(full), 32'(cnt == D));
        chk({tag, "_empty"}, 32'(empty), 32'(cnt == 0));
        chk({tag, "_data_out"}, 32'(data_out), 32'(dout));
        chk({tag, "_tx_active"}, 32'(tx_active), 32'(tx));
        chk({tag, "_overflow"}, 32'(overflow), 32'(ov));
        chk({tag, "_underflow"}, 32'(underflow), 32'(uf));
        if (chkbus) chk({tag, "_bus"}, 32'(data_io), 32'(exp_bus));
    endtask

    // Reference model: a word queue plus direction and remaining gap cycles.
    logic [W-1:0] q[$];
    int           m_mode;   // 0 receive, 1 gap toward transmit, 2 transmit, 3 gap toward receive
    int           m_gap;
    logic [W-1:0] m_dout;
    logic         m_ov, m_uf;

    function automatic void model_reset();
        q.delete();
        m_mode = 0; m_gap = 0; m_dout = '0; m_ov = 1'b0; m_uf = 1'b0;
    endfunction

    function automatic void model_step(input logic dir, cap, drv, clr, input logic [W-1:0] bus);
        if (clr) begin m_ov = 1'b0; m_uf = 1'b0; end
        case (m_mode)
            0: begin
                if (cap) begin
                    m_dout = bus;
                    if (q.size() < D) q.push_back(bus);
                    else m_ov = 1'b1;
                end
                if (dir) begin m_gap = T; m_mode = (T == 0) ? 2 : 1; end
            end
            2: begin
                if (drv) begin
                    if (q.size() > 0) void'(q.pop_front());
                    else m_uf = 1'b1;
                end
                if (!dir) begin m_gap = T; m_mode = (T == 0) ? 0 : 3; end
            end
            default: begin
                m_gap--;
                if (m_gap <= 0) m_mode = (m_mode == 1) ? 2 : 0;
            end
        endcase
    endfunction

    initial begin
        // Directed table: captures, overflow, turnaround, pops, underflow, wrap.
        vecs.push_back(mk(0,1,0,0,1,16'hA001, 1,16'hA001,0,0,0,0,'0));
        vecs.push_back(mk(0,1,0,0,1,16'hA002, 2,16'hA002,0,0,0,0,'0));
        vecs.push_back(mk(0,1,0,0,1,16'hA003, 3,16'hA003,0,0,0,0,'0));
        vecs.push_back(mk(0,1,0,0,1,16'hA004, 4,16'hA004,0,0,0,0,'0));
        vecs.push_back(mk(0,1,0,0,1,16'hBEEF, 4,16'hBEEF,0,1,0,0,'0));
        vecs.push_back(mk(0,0,0,1,1,16'h0000, 4,16'hBEEF,0,0,0,0,'0));
        vecs.push_back(mk(1,0,0,0,0,16'h0000, 4,16'hBEEF,0,0,0,0,'0));
        vecs.push_back(mk(1,0,0,0,0,16'h0000, 4,16'hBEEF,1,0,0,1,16'hA001));
        vecs.push_back(mk(1,0,1,0,0,16'h0000, 3,16'hBEEF,1,0,0,1,16'hA002));
        vecs.push_back(mk(1,0,1,0,0,16'h0000, 2,16'hBEEF,1,0,0,1,16'hA003));
        vecs.push_back(mk(1,0,1,0,0,16'h0000, 1,16'hBEEF,1,0,0,1,16'hA004));
        vecs.push_back(mk(1,0,1,0,0,16'h0000, 0,16'hBEEF,1,0,0,1,16'hA001));
        vecs.push_back(mk(1,0,1,0,0,16'h0000, 0,16'hBEEF,1,0,1,1,16'hA001));
        vecs.push_back(mk(1,0,1,1,0,16'h0000, 0,16'hBEEF,1,0,1,1,16'hA001));
        vecs.push_back(mk(1,0,0,1,0,16'h0000, 0,16'hBEEF,1,0,0,0,'0));
        vecs.push_back(mk(0,0,0,0,0,16'h0000, 0,16'hBEEF,0,0,0,0,'0));
        vecs.push_back(mk(0,1,0,0,0,16'h0000, 0,16'hBEEF,0,0,0,0,'0));
        vecs.push_back(mk(0,1,0,0,1,16'hC000, 1,16'hC000,0,0,0,0,'0));
        vecs.push_back(mk(0,1,0,0,1,16'hC001, 2,16'hC001,0,0,0,0,'0));
        vecs.push_back(mk(0,1,0,0,1,16'hC002, 3,16'hC002,0,0,0,0,'0));
        vecs.push_back(mk(0,1,0,0,1,16'hC003, 4,16'hC003,0,0,0,0,'0));
        vecs.push_back(mk(1,0,0,0,0,16'h0000, 4,16'hC003,0,0,0,0,'0));
        vecs.push_back(mk(1,0,0,0,0,16'h0000, 4,16'hC003,1,0,0,1,16'hC000));
        vecs.push_back(mk(1,0,1,0,0,16'h0000, 3,16'hC003,1,0,0,1,16'hC001));
        vecs.push_back(mk(1,0,1,0,0,16'h0000, 2,16'hC003,1,0,0,1,16'hC002));
        vecs.push_back(mk(1,0,1,0,0,16'h0000, 1,16'hC003,1,0,0,1,16'hC003));
        vecs.push_back(mk(0,0,0,0,0,16'h0000, 1,16'hC003,0,0,0,0,'0));
        vecs.push_back(mk(0,0,0,0,1,16'h0000, 1,16'hC003,0,0,0,0,'0));
        vecs.push_back(mk(0,1,0,0,1,16'hC004, 2,16'hC004,0,0,0,0,'0));
        vecs.push_back(mk(0,1,0,0,1,16'hC005, 3,16'hC005,0,0,0,0,'0));
        vecs.push_back(mk(0,1,0,0,1,16'hC006, 4,16'hC006,0,0,0,0,'0));
        vecs.push_back(mk(1,0,0,0,0,16'h0000, 4,16'hC006,0,0,0,0,'0));
        vecs.push_back(mk(1,0,0,0,0,16'h0000, 4,16'hC006,1,0,0,1,16'hC003));
        vecs.push_back(mk(1,0,1,0,0,16'h0000, 3,16'hC006,1,0,0,1,16'hC004));
        vecs.push_back(mk(1,0,1,0,0,16'h0000, 2,16'hC006,1,0,0,1,16'hC005));
        vecs.push_back(mk(1,0,1,0,0,16'h0000, 1,16'hC006,1,0,0,1,16'hC006));
        vecs.push_back(mk(1,1,1,0,0,16'h0000, 0,16'hC006,1,0,0,0,'0));

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus_en = 1'b1;
        #1;
        check_outputs("reset", 0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            dir_tx = vecs[i].dir; cap_en = vecs[i].cap; drv_en = vecs[i].drv;
            clr_err = vecs[i].clr; bus_en = vecs[i].drive; bus_drv = vecs[i].bus;
            tick();
            check_outputs($sformatf("row%0d", i), vecs[i].cnt, vecs[i].dout, vecs[i].tx,
                          vecs[i].ov, vecs[i].uf, vecs[i].chkbus, vecs[i].exp_bus);
        end

        // Asynchronous reset while driving 16'h5A5A.
        dir_tx = 1'b0; cap_en = 1'b0; drv_en = 1'b0; clr_err = 1'b0; bus_en = 1'b0;
        tick(); tick();
        bus_en = 1'b1; bus_drv = 16'h5A5A; cap_en = 1'b1;
        tick();
        cap_en = 1'b0; bus_en = 1'b0; dir_tx = 1'b1;
        tick(); tick();
        chk("pre_rst_tx_active", 32'(tx_active), 32'd1);
        chk("pre_rst_bus", 32'(data_io), 32'h5A5A);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tx_active", 32'(tx_active), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        rst = 1'b0; dir_tx = 1'b0; bus_en = 1'b1; bus_drv = 16'h1111; cap_en = 1'b1;
        tick();
        check_outputs("post_rst_cap", 1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Random traffic against the reference model.
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        dir_tx = 1'b0;
        for (int i = 0; i < NRAND; i++) begin
            if ($urandom_range(0, 7) == 0) dir_tx = ~dir_tx;
            cap_en  = $urandom_range(0, 1) == 1;
            drv_en  = $urandom_range(0, 1) == 1;
            clr_err = $urandom_range(0, 15) == 0;
            bus_drv = W'($urandom);
            bus_en  = (m_mode == 0);
            tick();
            model_step(dir_tx, cap_en, drv_en, clr_err, bus_drv);
            check_outputs($sformatf("rand%0d", i), q.size(), m_dout, m_mode == 2,
                          m_ov, m_uf, (m_mode == 2) && (q.size() > 0),
                          (q.size() > 0) ? q[0] : '0);
            if (n_err > 20) break;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
